biquad_cascade: RTL and testbench

BIQUAD_CASCADE -- requirements
Module: biquad_cascade

---
 rtl/biquad_cascade.sv | 253 +++++++++++++++++++++++++
 tb/tb_biquad_cascade.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_cascade.sv
// Cascade of NUM_STAGES direct-form-I biquads sharing one MAC, one section per cycle.
// Optional macro BIQUAD_ROUND_EN selects round-half-up instead of floor before saturation.
module biquad_cascade #(
    parameter int WIDTH      = 16,
    parameter int COEF_W     = 16,
    parameter int FRAC       = 14,
    parameter int NUM_STAGES = 2
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WIDTH-1:0]  x_n,
    output logic                     out_valid,
    output logic signed [WIDTH-1:0]  y_n,
    input  logic                     coef_we,
    input  logic [5:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int NCOEF  = 5 * NUM_STAGES;
    localparam int STG_W  = 3;
    localparam int PROD_W = WIDTH + COEF_W;
    localparam int ACC_W  = PROD_W + 3;

    localparam logic signed [COEF_W-1:0] B0_UNITY = COEF_W'(1) << FRAC;
    localparam logic signed [ACC_W-1:0]  SAT_MAX  = (ACC_W'(1) << (WIDTH - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN  = -(ACC_W'(1) << (WIDTH - 1));
`ifdef BIQUAD_ROUND_EN
    localparam logic signed [ACC_W-1:0]  RND_C    = ACC_W'(1) << (FRAC - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic signed [PROD_W-1:0] smul(
        input logic signed [COEF_W-1:0] c,
        input logic signed [WIDTH-1:0]  d
    );
        logic signed [PROD_W-1:0] ce;
        logic signed [PROD_W-1:0] de;
        ce = PROD_W'(c);
        de = PROD_W'(d);
        return ce * de;
    endfunction

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [PROD_W-1:0] p);
        return {{3{p[PROD_W-1]}}, p};
    endfunction

    // Returns {saturated_flag, clipped_sample}.
    function automatic logic [WIDTH:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b1, SAT_MAX[WIDTH-1:0]};
        end else if (v < SAT_MIN) begin
            return {1'b1, SAT_MIN[WIDTH-1:0]};
        end else begin
            return {1'b0, v[WIDTH-1:0]};
        end
    endfunction

    state_t                   state_q, state_d;
    logic [STG_W-1:0]         stage_q, stage_d;
    logic signed [COEF_W-1:0] coef_q [NCOEF];
    logic signed [WIDTH-1:0]  u1_q [NUM_STAGES];
    logic signed [WIDTH-1:0]  u2_q [NUM_STAGES];
    logic signed [WIDTH-1:0]  v1_q [NUM_STAGES];
    logic signed [WIDTH-1:0]  v2_q [NUM_STAGES];
    logic signed [WIDTH-1:0]  cur_q;
    logic signed [WIDTH-1:0]  y_q;
    logic                     out_valid_q;
    logic                     overflow_q;

    logic signed [COEF_W-1:0] sel_b0_s, sel_b1_s, sel_b2_s, sel_a1_s, sel_a2_s;
    logic signed [WIDTH-1:0]  sel_u1_s, sel_u2_s, sel_v1_s, sel_v2_s;
    logic signed [ACC_W-1:0]  acc_s, acc_r_s, shf_s;
    logic signed [WIDTH-1:0]  res_s;
    logic                     sat_flag_s;
    logic                     last_s;
    logic                     compute_s;
    logic                     accept_s;
    logic                     sat_s;

    assign in_ready  = (state_q == IDLE) && enable;
    assign accept_s  = in_valid && in_ready;
    assign last_s    = (stage_q == STG_W'(NUM_STAGES - 1));
    assign compute_s = enable && (state_q == RUN);
    assign sat_s     = compute_s && sat_flag_s;
    assign out_valid = out_valid_q;
    assign y_n       = y_q;
    assign overflow  = overflow_q;

    // Select the active section's coefficients/history and evaluate its difference equation.
    always_comb begin
        sel_b0_s = '0;
        sel_b1_s = '0;
        sel_b2_s = '0;
        sel_a1_s = '0;
        sel_a2_s = '0;
        sel_u1_s = '0;
        sel_u2_s = '0;
        sel_v1_s = '0;
        sel_v2_s = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            sel_b0_s = (stage_q == STG_W'(k)) ? coef_q[5*k]     : sel_b0_s;
            sel_b1_s = (stage_q == STG_W'(k)) ? coef_q[5*k + 1] : sel_b1_s;
            sel_b2_s = (stage_q == STG_W'(k)) ? coef_q[5*k + 2] : sel_b2_s;
            sel_a1_s = (stage_q == STG_W'(k)) ? coef_q[5*k + 3] : sel_a1_s;
            sel_a2_s = (stage_q == STG_W'(k)) ? coef_q[5*k + 4] : sel_a2_s;
            sel_u1_s = (stage_q == STG_W'(k)) ? u1_q[k]         : sel_u1_s;
            sel_u2_s = (stage_q == STG_W'(k)) ? u2_q[k]         : sel_u2_s;
            sel_v1_s = (stage_q == STG_W'(k)) ? v1_q[k]         : sel_v1_s;
            sel_v2_s = (stage_q == STG_W'(k)) ? v2_q[k]         : sel_v2_s;
        end
        acc_s = sext(smul(sel_b0_s, cur_q)) + sext(smul(sel_b1_s, sel_u1_s))
              + sext(smul(sel_b2_s, sel_u2_s)) - sext(smul(sel_a1_s, sel_v1_s))
              - sext(smul(sel_a2_s, sel_v2_s));
`ifdef BIQUAD_ROUND_EN
        acc_r_s = acc_s + RND_C;
`else
        acc_r_s = acc_s;
`endif
        shf_s = acc_r_s >>> FRAC;
        {sat_flag_s, res_s} = saturate(shf_s);
    end

    // Next-state logic; dropping enable abandons any sample in flight.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        if (!enable) begin
            state_d = IDLE;
            stage_d = STG_W'(0);
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = RUN;
                        stage_d = STG_W'(0);
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (last_s) begin
                        state_d = DONE;
                        stage_d = STG_W'(0);
                    end else begin
                        stage_d = stage_q + STG_W'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    stage_d = STG_W'(0);
                end
            endcase
        end
    end

    // FSM state and stage counter.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stage_q <= STG_W'(0);
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end

    // Coefficient bank; only writable while idle, out-of-range addresses never match.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NCOEF; j++) begin
                coef_q[j] <= ((j % 5) == 0) ? B0_UNITY : COEF_W'(0);
            end
        end else if (coef_we && (state_q == IDLE)) begin
            for (int j = 0; j < NCOEF; j++) begin
                if (coef_addr == 6'(j)) begin
                    coef_q[j] <= coef_wdata;
                end
            end
        end
    end

    // Per-section input/output history, advanced only when that section is evaluated.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                u1_q[k] <= WIDTH'(0);
                u2_q[k] <= WIDTH'(0);
                v1_q[k] <= WIDTH'(0);
                v2_q[k] <= WIDTH'(0);
            end
        end else if (!enable) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                u1_q[k] <= WIDTH'(0);
                u2_q[k] <= WIDTH'(0);
                v1_q[k] <= WIDTH'(0);
                v2_q[k] <= WIDTH'(0);
            end
        end else if (state_q == RUN) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (stage_q == STG_W'(k)) begin
                    u2_q[k] <= u1_q[k];
                    u1_q[k] <= cur_q;
                    v2_q[k] <= v1_q[k];
                    v1_q[k] <= res_s;
                end
            end
        end
    end

    // Section input pipeline register, output sample and its valid strobe.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cur_q       <= WIDTH'(0);
            y_q         <= WIDTH'(0);
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_d == DONE);
            if (accept_s) begin
                cur_q <= x_n;
            end else if (compute_s) begin
                cur_q <= res_s;
            end
            if (compute_s && last_s) begin
                y_q <= res_s;
            end
        end
    end

    // Sticky saturation flag; a new saturation wins over a simultaneous clear.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (sat_s) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_biquad_cascade.sv
// Directed, table-driven bench for biquad_cascade (default parameters, two sections).
module tb_biquad_cascade;

    localparam int N = 2;

    logic               CLK = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_n;
    logic               out_valid;
    logic signed [15:0] y_n;
    logic               coef_we;
    logic [5:0]         coef_addr;
    logic signed [15:0] coef_wdata;
    logic               overflow;
    logic               ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    biquad_cascade dut (
        .CLK(CLK), .rst_n(rst_n), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .x_n(x_n),
        .out_valid(out_valid), .y_n(y_n),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    typedef struct {
        bit clr;
        int b0, b1, b2, a1, a2, s1b0;
        int x, y;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input bit c, input int b0, input int b1, input int b2,
                                input int a1, input int a2, input int s1, input int x,
                                input int y);
        vec_t v;
        v.clr = c; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.a1 = a1; v.a2 = a2;
        v.s1b0 = s1; v.x = x; v.y = y;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic write_coef(input int addr, input int data);
        @(negedge CLK);
        coef_we = 1'b1; coef_addr = 6'(addr); coef_wdata = 16'(data);
        @(negedge CLK);
        coef_we = 1'b0;
    endtask

    // Pulse enable low to clear histories, then program stage 0 and stage-1 b0.
    task automatic load(input int b0, input int b1, input int b2, input int a1,
                        input int a2, input int s1);
        @(negedge CLK); enable = 1'b0;
        @(negedge CLK); enable = 1'b1;
        write_coef(0, b0); write_coef(1, b1); write_coef(2, b2);
        write_coef(3, a1); write_coef(4, a2); write_coef(5, s1);
    endtask

    // lat counts rising edges from the accept edge (inclusive) until out_valid is seen.
    task automatic run_sample(input int x, output int y, output int lat);
        @(negedge CLK);
        x_n = 16'(x); in_valid = 1'b1;
        chk("in_ready_idle", int'(in_ready), 1);
        @(posedge CLK); #1;
        in_valid = 1'b0; lat = 1;
        chk("in_ready_busy", int'(in_ready), 0);
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        y = int'(y_n);
        @(posedge CLK); #1;
        chk("out_valid_one_cycle", int'(out_valid), 0);
    endtask

    task automatic accept_only(input int x);
        @(negedge CLK);
        x_n = 16'(x); in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int y, lat, seen, e1, e2, cnt, exp_p, exp_n;

        vecs[0]  = mk(1'b1, 16384, 0, 0, 0, 0, 16384, 1000, 1000);
        vecs[1]  = mk(1'b1, 0, 16384, 0, 0, 0, 16384, 1000, 0);
        vecs[2]  = mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 1000);
        vecs[3]  = mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1'b1, 8192, 0, 0, 0, 0, 16384, 1000, 500);
        vecs[5]  = mk(1'b1, 16384, 0, 0, 0, 0, 16384, -1234, -1234);
        vecs[6]  = mk(1'b1, 16384, 0, 0, -8192, 0, 16384, 1000, 1000);
        vecs[7]  = mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 500);
        vecs[8]  = mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 250);
        vecs[9]  = mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 125);
        vecs[10] = mk(1'b1, 0, 0, 16384, 0, 0, 16384, 7, 0);
        vecs[11] = mk(1'b0, 0, 0, 0, 0, 0, 0, 8, 0);
        vecs[12] = mk(1'b0, 0, 0, 0, 0, 0, 0, 9, 7);
        vecs[13] = mk(1'b1, 16384, 0, 0, 0, 8192, 16384, 400, 400);
        vecs[14] = mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(1'b0, 0, 0, 0, 0, 0, 0, 0, -200);
        vecs[16] = mk(1'b1, 16384, 0, 0, 0, 0, -16384, 500, -500);

        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; x_n = 16'sd0;
        coef_we = 1'b0; coef_addr = 6'd0; coef_wdata = 16'sd0; ovf_clr = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_y_n", int'(y_n), 0);
        chk("reset_overflow", int'(overflow), 0);
        @(negedge CLK); rst_n = 1'b1;
        #1;
        chk("reset_in_ready", int'(in_ready), 1);

        // Unity passthrough straight out of reset.
        run_sample(1000, y, lat);
        chk("post_reset_y", y, 1000);
        chk("post_reset_latency", lat, N + 1);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].clr) begin
                load(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].a1, vecs[i].a2, vecs[i].s1b0);
            end
            run_sample(vecs[i].x, y, lat);
            chk($sformatf("vec%0d_y", i), y, vecs[i].y);
            chk($sformatf("vec%0d_latency", i), lat, N + 1);
        end
        chk("table_no_overflow", int'(overflow), 0);

        // Saturation in both directions, sticky flag, and clear.
        load(32767, 0, 0, 0, 0, 16384);
        run_sample(30000, y, lat);
        chk("sat_pos_y", y, 32767);
        chk("sat_pos_ovf", int'(overflow), 1);
        run_sample(-30000, y, lat);
        chk("sat_neg_y", y, -32768);
        run_sample(0, y, lat);
        chk("sat_zero_y", y, 0);
        chk("ovf_sticky", int'(overflow), 1);
        @(negedge CLK); ovf_clr = 1'b1;
        @(negedge CLK); ovf_clr = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);

        // Clear asserted exactly on the saturating stage-0 edge must lose.
        accept_only(30000);
        ovf_clr = 1'b1;
        @(posedge CLK); #1;
        ovf_clr = 1'b0;
        chk("ovf_clr_vs_sat", int'(overflow), 1);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(posedge CLK); #1; cnt++;
        end
        chk("ovf_clr_vs_sat_y", int'(y_n), 32767);
        @(posedge CLK); #1;

        // Half-gain rounding corner.
`ifdef BIQUAD_ROUND_EN
        exp_p = 1; exp_n = 0;
`else
        exp_p = 0; exp_n = -1;
`endif
        load(8192, 0, 0, 0, 0, 16384);
        run_sample(1, y, lat);
        chk("round_pos_one", y, exp_p);
        run_sample(-1, y, lat);
        chk("round_neg_one", y, exp_n);

        // Coefficient write during RUN/DONE is ignored.
        load(16384, 0, 0, 0, 0, 16384);
        accept_only(1000);
        coef_we = 1'b1; coef_addr = 6'd0; coef_wdata = 16'sd8192;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(posedge CLK); #1; cnt++;
        end
        chk("busy_write_y", int'(y_n), 1000);
        @(posedge CLK); #1;
        coef_we = 1'b0;
        run_sample(1000, y, lat);
        chk("busy_write_next_y", y, 1000);

        // enable=0 aborts in flight, clears history, keeps coefficients and y_n.
        load(8192, 16384, 0, 0, 0, 16384);
        run_sample(1000, y, lat);
        chk("abort_pre_y", y, 500);
        accept_only(2000);
        enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_out_valid", seen, 0);
        chk("abort_y_held", int'(y_n), 500);
        chk("abort_in_ready_low", int'(in_ready), 0);
        @(negedge CLK); enable = 1'b1;
        run_sample(600, y, lat);
        chk("abort_history_cleared", y, 300);

        // Reset one cycle after accept.
        accept_only(1000);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_out_valid", int'(out_valid), 0);
        chk("midrun_reset_y", int'(y_n), 0);
        @(posedge CLK);
        @(negedge CLK); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            if (out_valid) seen++;
        end
        chk("midrun_reset_no_out_valid", seen, 0);
        run_sample(1000, y, lat);
        chk("midrun_reset_fresh_y", y, 1000);
        chk("midrun_reset_fresh_latency", lat, N + 1);

        // Back-to-back samples: one result every N+2 cycles.
        @(negedge CLK);
        x_n = 16'sd77; in_valid = 1'b1;
        e1 = -1; e2 = -1;
        for (int e = 0; e < 30; e++) begin
            @(posedge CLK); #1;
            if (out_valid && e1 < 0) e1 = e;
            else if (out_valid && e2 < 0) e2 = e;
            if (e2 >= 0) break;
        end
        in_valid = 1'b0;
        chk("throughput_gap", e2 - e1, N + 2);
        chk("throughput_y", int'(y_n), 77);
        repeat (6) @(posedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
